// File: rtl/scan_pkg.sv
// scan_pkg
// Shared definitions for the scan select generator: FSM state encoding and
// the width/count of the scanned output index.
package scan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHOW  = 2'd1,
        ST_BLANK = 2'd2
    } state_t;

    localparam int IDX_W   = 2;
    localparam int NUM_OUT = 4;

endpackage

// File: rtl/scan_next_idx.sv
// scan_next_idx
// Rotate-priority search for the next enabled output index.
//   cur_idx  in   current index, the search starts here
//   mask     in   mask[i]=1 means output i may be selected
//   incl_cur in   1 = cur_idx itself is the first candidate,
//                 0 = search starts at cur_idx+1 and cur_idx is tried last
//   nxt_idx  out  first enabled candidate; cur_idx when mask is all zero
module scan_next_idx
    import scan_pkg::*;
(
    input  logic [IDX_W-1:0]   cur_idx,
    input  logic [NUM_OUT-1:0] mask,
    input  logic               incl_cur,
    output logic [IDX_W-1:0]   nxt_idx
);

    logic [IDX_W-1:0] cand;
    logic [IDX_W-1:0] step;
    logic             found;

    // With incl_cur=0 the offsets run 1..4, so the last candidate wraps back
    // onto cur_idx: a single enabled output keeps its index.
    assign step = {1'b0, ~incl_cur};

    always_comb begin
        nxt_idx = cur_idx;
        cand    = '0;
        found   = 1'b0;
        for (int k = 0; k < NUM_OUT; k++) begin
            cand = cur_idx + IDX_W'(k) + step;
            if (!found && mask[cand]) begin
                nxt_idx = cand;
                found   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/scan_sel_gen.sv
// scan_sel_gen
// Sequencer for a 2-to-4 decoder: walks the enabled outputs, holding each
// for DWELL_CYCLES with the enable high and separating them with
// BLANK_CYCLES of enable low. The select code only moves while the enable
// is low, so the decoded line never glitches.
//   SYSCLK    in   system clock, rising edge
//   NSYSRESET in   synchronous active-low reset
//   run       in   1 = scan, 0 = hold (enable off, index frozen)
//   mask      in   mask[i]=1 means output i takes part in the scan
//   sel_a     out  select LSB (idx[0])
//   sel_b     out  select MSB (idx[1])
//   sel_en    out  decoder enable
//   idx       out  current output index {sel_b, sel_a}
//   tick      out  one-cycle pulse when the index is advanced in BLANK
//
// state    | meaning
// ---------+-----------------------------------------------
// ST_IDLE  | enable low, waiting for run=1 and a non-zero mask
// ST_SHOW  | enable high, counting out the dwell time
// ST_BLANK | enable low, index advances in the first cycle
module scan_sel_gen
    import scan_pkg::*;
#(
    parameter int DWELL_CYCLES = 1000,
    parameter int BLANK_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic               SYSCLK,
    input  logic               NSYSRESET,
    input  logic               run,
    input  logic [NUM_OUT-1:0] mask,
    output logic               sel_a,
    output logic               sel_b,
    output logic               sel_en,
    output logic [IDX_W-1:0]   idx,
    output logic               tick
);

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [IDX_W-1:0] idx_nxt;
    logic [IDX_W-1:0] search_idx;
    logic             tick_nxt;

    // IDLE->SHOW may keep the current index; the BLANK advance must move on.
    scan_next_idx u_next_idx (
        .cur_idx  (idx),
        .mask     (mask),
        .incl_cur (state == ST_IDLE),
        .nxt_idx  (search_idx)
    );

    always_ff @(posedge SYSCLK) begin
        if (!NSYSRESET) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            idx    <= '0;
            sel_en <= 1'b0;
            tick   <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            idx    <= idx_nxt;
            sel_en <= (state_nxt == ST_SHOW);
            tick   <= tick_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = idx;
        tick_nxt  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (run && (mask != '0)) begin
                    state_nxt = ST_SHOW;
                    cnt_nxt   = '0;
                    idx_nxt   = search_idx;
                end
            end
            ST_SHOW: begin
                // run=0 takes priority over dwell expiry; counter is left
                // as-is and cleared again on the way back into SHOW.
                if (!run) begin
                    state_nxt = ST_IDLE;
                end else if (cnt == DWELL_LAST) begin
                    state_nxt = ST_BLANK;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            ST_BLANK: begin
                if (!run) begin
                    state_nxt = ST_IDLE;
                end else begin
                    if (cnt == '0) begin
                        idx_nxt  = search_idx;
                        tick_nxt = 1'b1;
                    end
                    if (cnt == BLANK_LAST) begin
                        cnt_nxt   = '0;
                        state_nxt = (mask != '0) ? ST_SHOW : ST_IDLE;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign sel_a = idx[0];
    assign sel_b = idx[1];

endmodule

// File: tb/tb_scan_sel_gen.sv
// tb_scan_sel_gen
// Vector table of {inputs, expected outputs} per rising edge, built up front
// from the scan timeline (DWELL=4, BLANK=2, period 6). Each row's expectation
// is queued when its inputs are driven and popped after the edge.
module tb_scan_sel_gen;

    localparam int DW  = 4;
    localparam int BW  = 2;
    localparam int PER = DW + BW;

    logic       SYSCLK = 1'b0;
    logic       NSYSRESET;
    logic       run;
    logic [3:0] mask;
    logic       sel_a, sel_b, sel_en, tick;
    logic [1:0] idx;

    always #5 SYSCLK = ~SYSCLK;

    scan_sel_gen #(
        .DWELL_CYCLES (DW),
        .BLANK_CYCLES (BW),
        .CNT_W        (8)
    ) dut (
        .SYSCLK    (SYSCLK),
        .NSYSRESET (NSYSRESET),
        .run       (run),
        .mask      (mask),
        .sel_a     (sel_a),
        .sel_b     (sel_b),
        .sel_en    (sel_en),
        .idx       (idx),
        .tick      (tick)
    );

    typedef struct {
        int         sc;
        int         step;
        logic       rst_b;
        logic       run;
        logic [3:0] mask;
        logic       en;
        logic [1:0] idx;
        logic       tick;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cur_sc = 0;
    int   cur_step = 0;

    function automatic void add(input logic rst_b, input logic r, input logic [3:0] m,
                                input logic en, input logic [1:0] id, input logic tk);
        vec_t v;
        cur_step++;
        v.sc = cur_sc; v.step = cur_step;
        v.rst_b = rst_b; v.run = r; v.mask = m;
        v.en = en; v.idx = id; v.tick = tk;
        vecs.push_back(v);
    endfunction

    function automatic void new_sc(input int sc);
        cur_sc = sc;
        cur_step = 0;
        add(1'b0, 1'b0, 4'h0, 1'b0, 2'd0, 1'b0);
        add(1'b0, 1'b0, 4'h0, 1'b0, 2'd0, 1'b0);
    endfunction

    // Free-running scan from IDLE with idx=0: edge n (1-based) is at phase
    // p=(n-1)%PER of digit d; enable high for p<DW, index moves at p=PER-1.
    // order packs the visited indices, order[1:0] first.
    function automatic void add_scan(input logic [3:0] m, input logic [7:0] order, input int n_edges);
        for (int n = 1; n <= n_edges; n++) begin
            int p, d, sel;
            logic [1:0] id;
            p   = (n - 1) % PER;
            d   = ((n - 1) / PER) % 4;
            sel = (p == PER - 1) ? (d + 1) % 4 : d;
            id  = order[2*sel +: 2];
            add(1'b1, 1'b1, m, p < DW, id, p == PER - 1);
        end
    endfunction

    function automatic void chk(input string name, input vec_t v, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s scen %0d step %0d: got %0d expected %0d", name, v.sc, v.step, got, exp);
        end
    endfunction

    // Select code must not move while the enable stays high.
    logic       prev_en = 1'b0;
    logic [1:0] prev_sel = 2'd0;
    always @(negedge SYSCLK) begin
        if (prev_en === 1'b1 && sel_en === 1'b1) begin
            n_cmp++;
            if ({sel_b, sel_a} !== prev_sel) begin
                n_bad++;
                $display("FAIL glitch at %0t: sel moved %0d -> %0d with sel_en high", $time, prev_sel, {sel_b, sel_a});
            end
        end
        prev_en  = sel_en;
        prev_sel = {sel_b, sel_a};
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v, e;
        NSYSRESET = 1'b0;
        run       = 1'b0;
        mask      = 4'h0;

        // 1: full mask, 0,1,2,3,0...
        new_sc(1);
        add_scan(4'b1111, 8'b11_10_01_00, 30);

        // 2: mask 1010 visits 1,3,1,3
        new_sc(2);
        add_scan(4'b1010, 8'b11_01_11_01, 24);

        // 3: run dropped mid-SHOW, resumed later on the same index
        new_sc(3);
        for (int n = 1; n <= 3; n++) add(1'b1, 1'b1, 4'hF, 1'b1, 2'd0, 1'b0);
        for (int n = 4; n <= 10; n++) add(1'b1, 1'b0, 4'hF, 1'b0, 2'd0, 1'b0);
        for (int n = 11; n <= 14; n++) add(1'b1, 1'b1, 4'hF, 1'b1, 2'd0, 1'b0);
        add(1'b1, 1'b1, 4'hF, 1'b0, 2'd0, 1'b0);
        add(1'b1, 1'b1, 4'hF, 1'b0, 2'd1, 1'b1);
        add(1'b1, 1'b1, 4'hF, 1'b1, 2'd1, 1'b0);
        add(1'b1, 1'b1, 4'hF, 1'b1, 2'd1, 1'b0);

        // 4: empty mask holds IDLE; single output 2 re-selects itself with a tick
        new_sc(4);
        for (int n = 1; n <= 50; n++) add(1'b1, 1'b1, 4'h0, 1'b0, 2'd0, 1'b0);
        for (int n = 51; n <= 54; n++) add(1'b1, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b0);
        add(1'b1, 1'b1, 4'b0100, 1'b0, 2'd2, 1'b0);
        add(1'b1, 1'b1, 4'b0100, 1'b0, 2'd2, 1'b1);
        add(1'b1, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b0);

        // 5: reset mid-SHOW on idx 1, then a clean restart
        new_sc(5);
        add_scan(4'b1111, 8'b11_10_01_00, 7);
        add(1'b0, 1'b1, 4'hF, 1'b0, 2'd0, 1'b0);
        add_scan(4'b1111, 8'b11_10_01_00, 30);

        // 6: mask cleared in BLANK, rotate-load from idx 1, mask change in SHOW,
        //    run dropped in the advance cycle of BLANK
        new_sc(6);
        add_scan(4'b1111, 8'b11_10_01_00, 6);
        for (int n = 7; n <= 12; n++) add(1'b1, 1'b1, 4'h0, 1'b0, 2'd1, 1'b0);
        add(1'b1, 1'b1, 4'b1000, 1'b1, 2'd3, 1'b0);
        for (int n = 14; n <= 16; n++) add(1'b1, 1'b1, 4'hF, 1'b1, 2'd3, 1'b0);
        add(1'b1, 1'b1, 4'hF, 1'b0, 2'd3, 1'b0);
        add(1'b1, 1'b1, 4'hF, 1'b0, 2'd0, 1'b1);
        for (int n = 19; n <= 22; n++) add(1'b1, 1'b1, 4'hF, 1'b1, 2'd0, 1'b0);
        add(1'b1, 1'b1, 4'hF, 1'b0, 2'd0, 1'b0);
        add(1'b1, 1'b0, 4'hF, 1'b0, 2'd0, 1'b0);
        for (int n = 25; n <= 28; n++) add(1'b1, 1'b1, 4'hF, 1'b1, 2'd0, 1'b0);
        add(1'b1, 1'b1, 4'hF, 1'b0, 2'd0, 1'b0);
        add(1'b1, 1'b1, 4'hF, 1'b0, 2'd1, 1'b1);

        // 7: run=0 on the dwell-expiry edge goes to IDLE, not BLANK
        new_sc(7);
        for (int n = 1; n <= 4; n++) add(1'b1, 1'b1, 4'hF, 1'b1, 2'd0, 1'b0);
        add(1'b1, 1'b0, 4'hF, 1'b0, 2'd0, 1'b0);
        for (int n = 6; n <= 9; n++) add(1'b1, 1'b1, 4'hF, 1'b1, 2'd0, 1'b0);
        add(1'b1, 1'b1, 4'hF, 1'b0, 2'd0, 1'b0);
        add(1'b1, 1'b1, 4'hF, 1'b0, 2'd1, 1'b1);
        add(1'b1, 1'b1, 4'hF, 1'b1, 2'd1, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            @(negedge SYSCLK);
            NSYSRESET = v.rst_b;
            run       = v.run;
            mask      = v.mask;
            exp_q.push_back(v);
            @(posedge SYSCLK);
            #1;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL scoreboard: queue empty at vector %0d", i);
            end else begin
                e = exp_q.pop_front();
                chk("sel_en", e, int'(sel_en), int'(e.en));
                chk("idx", e, int'(idx), int'(e.idx));
                chk("sel_ba", e, int'({sel_b, sel_a}), int'(e.idx));
                chk("tick", e, int'(tick), int'(e.tick));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/scan_sel_gen.md
Name: scan_sel_gen

Overview:
Upstream sequencer for the 2-to-4 decoder stage: it generates the 2-bit select code (a, b) and enable that the decoder turns into a one-hot line. It cycles through four outputs (display digits or LED banks), holds each for a programmable dwell time and inserts blanking gaps. The select code only changes while the enable is low, so the decoder output never glitches. A mask skips unused outputs, and run/hold control freezes the scan.

Parameters:
DWELL_CYCLES, 1000, clock cycles sel_en stays high per output (≥1).
BLANK_CYCLES, 2, clock cycles sel_en stays low between outputs (≥2).
CNT_W, 16, width of the dwell/blank counter (must hold max(DWELL_CYCLES, BLANK_CYCLES)).

Ports:
SYSCLK      in   1  system clock, all logic on the rising edge
NSYSRESET   in   1  reset; one clock, reset is synchronous and active-low
run         in   1  1 = scan, 0 = hold (enable off, state frozen)
mask        in   4  mask[i]=1 means output i takes part in the scan
sel_a       out  1  select LSB (idx[0]), drives decoder a
sel_b       out  1  select MSB (idx[1]), drives decoder b
sel_en      out  1  decoder enable
idx         out  2  current output index {sel_b, sel_a}
tick        out  1  one-cycle pulse in the cycle idx changes during BLANK

Behaviour:
- All outputs are registered. Reset (NSYSRESET=0 at a rising edge) gives: state IDLE, idx=0, sel_en=0, tick=0, counter=0. Reset overrides everything, including mid-SHOW or mid-BLANK.
- States:
  - IDLE: sel_en=0.
  - SHOW: sel_en=1.
  - BLANK: sel_en=0.
- IDLE→SHOW when run=1 and mask≠0.
  - idx loads the first enabled index at or after the current idx, searching upward mod 4.
  - counter clears to 0.
- SHOW: the counter increments each cycle. When counter=DWELL_CYCLES-1, go to BLANK and clear the counter. sel_en is therefore high for exactly DWELL_CYCLES cycles.
- BLANK: the counter increments each cycle.
  - In the first BLANK cycle (counter=0), idx advances to the next enabled index after the current one, searching upward with wrap 3→0, using the mask sampled in that cycle.
  - tick=1 in the same cycle the new idx appears. If the only enabled index is the current one, idx is unchanged and tick still pulses.
  - When counter=BLANK_CYCLES-1, go to SHOW and clear the counter.
- Digit period = DWELL_CYCLES + BLANK_CYCLES. sel_a/sel_b are stable during every SHOW cycle and change at least one cycle after sel_en falls and at least one cycle before it rises.
- run=0 in SHOW or BLANK: at the next edge go to IDLE with sel_en=0. idx is held and the counter is held and then cleared on resume; no tick.
- run=1 again: normal IDLE→SHOW, same idx if it is still enabled.
- mask becomes 0 while scanning: at the next BLANK exit go to IDLE instead of SHOW. While mask=0, stay in IDLE.
- mask changes during SHOW: no effect until the next advance.
- Counter arithmetic is unsigned CNT_W-bit. Compares are equality only and never wrap, given legal parameters.
- Simultaneous run=0 and a dwell-expiry edge: run wins, go to IDLE.

Decomposition:
- Shared package scan_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_SHOW=2'd1, ST_BLANK=2'd2;
  - IDX_W=2;
  - NUM_OUT=4.
- One combinational sub-module, scan_next_idx (inputs cur_idx, mask, incl_cur; output nxt_idx). It is a rotate-priority search used by both the IDLE→SHOW load (incl_cur=1) and the BLANK advance (incl_cur=0).
- The FSM, counter and output registers stay in scan_sel_gen.

Test Plan:
Edge 1 is the first rising edge with NSYSRESET=1 and run=1; the bench uses DWELL_CYCLES=4, BLANK_CYCLES=2.
1. Reset release, run=1, mask=4'b1111:
   - sel_en=1 at edges 1-4 with idx=0; sel_en=0 at edges 5-6;
   - idx=1 and tick=1 at edge 6; sel_en=1 at edge 7 with idx=1;
   - idx sequence 0,1,2,3,0 at edges 1, 7, 13, 19, 25.
2. mask=4'b1010 → SHOW idx=1 first (0 skipped), then 3, then 1. tick at edges 6, 12, 18. idx never 0 or 2.
3. run=0 asserted at edge 3 (mid-SHOW, idx=0):
   - sel_en=0 from edge 4, idx holds at 0, no tick;
   - run=1 at edge 10 → sel_en=1 at edge 11 with idx=0 for 4 full cycles.
4. mask=4'b0000 from reset with run=1 → sel_en stays 0 and idx=0 for 50 cycles. Then mask=4'b0100 → SHOW with idx=2 on the next edge.
5. NSYSRESET=0 at edge 8 (mid-SHOW, idx=1) → next edge idx=0, sel_en=0, tick=0. Resume after release matches scenario 1.
6. Glitch check across all scenarios: at every edge where sel_en=1 in both the current and previous cycle, sel_a/sel_b are unchanged. The bench asserts this continuously.
